// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 interface: pointer-based storage,
// optional fall-through, flush, and occupancy output.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam logic [ADDR_DEPTH:0]   FullCnt = (ADDR_DEPTH+1)'(DEPTH);
  localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic                  wr_en, rd_en, bypass;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  assign full_o  = (cnt_q == FullCnt);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  // A fall-through FIFO hands a pushed word straight to a same-cycle pop when empty.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign empty_o = (cnt_q == '0) && !bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
  assign wr_en   = push_i && !full_o && !(bypass && pop_i);
  assign rd_en   = pop_i && !empty_o && !(bypass && pop_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (wr_en && !rd_en)      cnt_q <= cnt_q + 1'b1;
      else if (rd_en && !wr_en) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/axi_aw_w_sequencer.sv
// Shares one AXI write master among NoSlvPorts requesters: round-robin AW grant with
// AXI-stable lock, and W bursts steered in AW-grant order through an in-order FIFO.
module axi_aw_w_sequencer #(
  parameter int unsigned NoSlvPorts = 4,
  parameter int unsigned MaxWTrans  = 8,
  parameter int unsigned SelWidth   = $clog2(NoSlvPorts)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_i,
  input  logic [NoSlvPorts-1:0] slv_aw_valid_i,
  output logic [NoSlvPorts-1:0] slv_aw_ready_o,
  output logic                  mst_aw_valid_o,
  input  logic                  mst_aw_ready_i,
  output logic [SelWidth-1:0]   aw_sel_o,
  input  logic [NoSlvPorts-1:0] slv_w_valid_i,
  input  logic [NoSlvPorts-1:0] slv_w_last_i,
  output logic [NoSlvPorts-1:0] slv_w_ready_o,
  output logic                  mst_w_valid_o,
  input  logic                  mst_w_ready_i,
  output logic [SelWidth-1:0]   w_sel_o,
  output logic                  w_sel_valid_o
);
  localparam logic [SelWidth-1:0] LastIdx = SelWidth'(NoSlvPorts - 1);
  localparam int unsigned FifoAddr = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;

  logic [SelWidth-1:0] rr_q, lock_idx_q, cand, aw_sel, head;
  logic                lock_q, aw_hs, w_pop, fifo_full, fifo_empty;
  logic [FifoAddr-1:0] fifo_usage_unused;

  always_comb begin
    int unsigned idx;
    logic        found;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NoSlvPorts; i++) begin
      idx = (32'(rr_q) + i) % NoSlvPorts;
      if (!found && slv_aw_valid_i[idx]) begin
        cand  = idx[SelWidth-1:0];
        found = 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is asserted, even with requests still pending.
  assign aw_sel         = lock_q ? lock_idx_q : cand;
  assign aw_sel_o       = rst_ni ? aw_sel : '0;
  assign mst_aw_valid_o = rst_ni & (lock_q | ((|slv_aw_valid_i) & ~fifo_full));
  assign aw_hs          = mst_aw_valid_o & mst_aw_ready_i;

  always_comb begin
    slv_aw_ready_o = '0;
    if (aw_hs) slv_aw_ready_o[aw_sel] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (aw_hs) begin
      rr_q   <= (aw_sel == LastIdx) ? '0 : aw_sel + 1'b1;
      lock_q <= 1'b0;
    end else if (mst_aw_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= aw_sel;
    end
  end

  assign w_sel_valid_o = ~fifo_empty;
  assign w_sel_o       = fifo_empty ? '0 : head;
  assign mst_w_valid_o = ~fifo_empty & slv_w_valid_i[head];
  assign w_pop         = mst_w_valid_o & mst_w_ready_i & slv_w_last_i[head];

  always_comb begin
    slv_w_ready_o = '0;
    if (!fifo_empty && mst_w_ready_i) slv_w_ready_o[head] = 1'b1;
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (SelWidth),
    .DEPTH        (MaxWTrans)
  ) i_grant_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (test_i),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (fifo_usage_unused),
    .data_i     (aw_sel),
    .push_i     (aw_hs),
    .data_o     (head),
    .pop_i      (w_pop)
  );
endmodule

// File: tb/tb_axi_aw_w_sequencer.sv
// Directed scenarios plus randomized traffic against a queue-based model of the
// arbitration order and W steering.
module tb_axi_aw_w_sequencer;
  localparam int N = 4;
  localparam int D = 2;

  logic         clk = 1'b0, rst_n = 1'b0, test = 1'b0;
  logic [N-1:0] aw_valid = '0, aw_ready, w_valid = '0, w_last = '0, w_ready;
  logic         m_aw_valid, m_aw_ready = 1'b0, m_w_valid, m_w_ready = 1'b0, w_sel_valid;
  logic [1:0]   aw_sel, w_sel;

  always #5 clk = ~clk;

  axi_aw_w_sequencer #(.NoSlvPorts(N), .MaxWTrans(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_i(test),
    .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(aw_ready),
    .mst_aw_valid_o(m_aw_valid), .mst_aw_ready_i(m_aw_ready), .aw_sel_o(aw_sel),
    .slv_w_valid_i(w_valid), .slv_w_last_i(w_last), .slv_w_ready_o(w_ready),
    .mst_w_valid_o(m_w_valid), .mst_w_ready_i(m_w_ready),
    .w_sel_o(w_sel), .w_sel_valid_o(w_sel_valid)
  );

  int total = 0, bad = 0;

  // reference state: next RR start, pending lock, grant-order queue
  int ptr = 0;
  bit locked = 0;
  int lock_idx = 0;
  int q[$];

  logic [31:0] s_aw_sel, s_aw_ready, s_aw_valid, s_w_sel, s_w_ready, s_w_valid, s_w_sel_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] av, input logic ar, input logic [N-1:0] wv,
                      input logic [N-1:0] wl, input logic wr);
    int exp_sel, head;
    bit exp_valid, full, empty;
    logic [N-1:0] exp_awr, exp_wr;
    #1;
    aw_valid = av; m_aw_ready = ar; w_valid = wv; w_last = wl; m_w_ready = wr;
    #4;
    full  = (q.size() == D);
    empty = (q.size() == 0);
    head  = empty ? 0 : q[0];
    exp_sel = 0;
    if (locked) begin
      exp_valid = 1; exp_sel = lock_idx;
    end else begin
      exp_valid = (av != 0) && !full;
      for (int i = 0; i < N; i++) begin
        if (av[(ptr + i) % N]) begin exp_sel = (ptr + i) % N; break; end
      end
    end
    exp_awr = '0; if (exp_valid && ar) exp_awr[exp_sel] = 1'b1;
    exp_wr  = '0; if (!empty && wr) exp_wr[head] = 1'b1;
    s_aw_sel = 32'(aw_sel); s_aw_ready = 32'(aw_ready); s_aw_valid = 32'(m_aw_valid);
    s_w_sel = 32'(w_sel); s_w_ready = 32'(w_ready); s_w_valid = 32'(m_w_valid);
    s_w_sel_valid = 32'(w_sel_valid);
    chk("aw_valid", s_aw_valid, 32'(exp_valid));
    if (exp_valid) chk("aw_sel", s_aw_sel, exp_sel);
    chk("aw_ready", s_aw_ready, 32'(exp_awr));
    chk("w_sel_valid", s_w_sel_valid, 32'(!empty));
    chk("w_sel", s_w_sel, head);
    chk("w_valid", s_w_valid, 32'(!empty && wv[head]));
    chk("w_ready", s_w_ready, 32'(exp_wr));
    @(posedge clk);
    if (!empty && wv[head] && wr && wl[head]) void'(q.pop_front());
    if (exp_valid && ar) begin
      q.push_back(exp_sel);
      ptr = (exp_sel + 1) % N;
      locked = 0;
    end else if (exp_valid) begin
      locked = 1; lock_idx = exp_sel;
    end
  endtask

  task automatic do_reset(input bit busy);
    #2;
    if (busy) begin aw_valid = '1; w_valid = '1; m_aw_ready = 1; m_w_ready = 1; end
    rst_n = 0;
    #1;
    chk("rst_aw_valid", 32'(m_aw_valid), 0);
    chk("rst_aw_ready", 32'(aw_ready), 0);
    chk("rst_aw_sel", 32'(aw_sel), 0);
    chk("rst_w_valid", 32'(m_w_valid), 0);
    chk("rst_w_ready", 32'(w_ready), 0);
    chk("rst_w_sel", 32'(w_sel), 0);
    chk("rst_w_sel_valid", 32'(w_sel_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    ptr = 0; locked = 0; q.delete();
  endtask

  int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
  int wo_exp[6] = '{2, 2, 0, 0, 0, 0};

  initial begin
    logic [N-1:0] av, wl;
    do_reset(0);

    // reset in the middle of port 2's W burst
    step(4'b0100, 1, 4'b0000, 4'b0000, 0);
    step(4'b0000, 0, 4'b0100, 4'b0000, 1);
    step(4'b0000, 0, 4'b0100, 4'b0000, 1);
    do_reset(1);
    step(4'b1111, 1, 4'b0000, 4'b0000, 0);
    chk("rst_ptr", s_aw_sel, 0);
    chk("rst_fifo_empty", s_w_sel_valid, 0);

    // round robin over ports 0,1,3 with single-beat bursts draining each cycle
    do_reset(0);
    for (int i = 0; i < 6; i++) begin
      step(4'b1011, 1, 4'b1111, 4'b1111, 1);
      chk("rr_sel", s_aw_sel, rr_exp[i]);
      chk("rr_onehot", s_aw_ready, 32'(1) << rr_exp[i]);
    end

    // lock holds port 1 while higher-priority port 0 appears
    do_reset(0);
    step(4'b0010, 0, 4'b0000, 4'b0000, 0); chk("lock_sel0", s_aw_sel, 1);
    step(4'b0011, 0, 4'b0000, 4'b0000, 0); chk("lock_sel1", s_aw_sel, 1);
    step(4'b0011, 0, 4'b0000, 4'b0000, 0); chk("lock_sel2", s_aw_sel, 1);
    step(4'b0011, 1, 4'b0000, 4'b0000, 0); chk("lock_hs", s_aw_ready, 32'b0010);
    step(4'b0011, 1, 4'b0000, 4'b0000, 0); chk("lock_next", s_aw_sel, 0);
    chk("lock_valid", s_aw_valid, 1);

    // W ordering: grants 2 then 0, port 0 W waits behind port 2's burst
    do_reset(0);
    step(4'b0100, 1, 4'b0001, 4'b0000, 1); chk("wo_nofall", s_w_ready, 0);
    step(4'b0001, 1, 4'b0001, 4'b0000, 1); chk("wo_stall", s_w_ready, 32'b0100);
    for (int k = 0; k < 6; k++) begin
      wl = (k == 1) ? 4'b0100 : (k == 4) ? 4'b0001 : 4'b0000;
      step(4'b0000, 0, 4'b0101, wl, 1);
      chk("wo_sel", s_w_sel, wo_exp[k]);
      if (k < 2) chk("wo_p0_blocked", 32'(s_w_ready[0]), 0);
    end

    // FIFO full blocks AW; a freed slot is visible only the following cycle
    do_reset(0);
    step(4'b0001, 1, 4'b0000, 4'b0000, 0);
    step(4'b0010, 1, 4'b0000, 4'b0000, 0);
    step(4'b0100, 1, 4'b0000, 4'b0000, 0); chk("full_blk", s_aw_valid, 0);
    step(4'b0100, 1, 4'b0001, 4'b0001, 1); chk("full_pop_cycle", s_aw_valid, 0);
    step(4'b0100, 1, 4'b0000, 4'b0000, 0); chk("full_after", s_aw_valid, 1);
    chk("full_after_sel", s_aw_sel, 2);

    // simultaneous push and last-pop keeps occupancy at one
    do_reset(0);
    step(4'b0010, 1, 4'b0000, 4'b0000, 0);
    step(4'b0100, 1, 4'b0010, 4'b0010, 1); chk("pp_head_old", s_w_sel, 1);
    step(4'b0000, 0, 4'b0000, 4'b0000, 0); chk("pp_head_new", s_w_sel, 2);
    chk("pp_occupied", s_w_sel_valid, 1);
    step(4'b0000, 0, 4'b0100, 4'b0100, 1);
    step(4'b0000, 0, 4'b0000, 4'b0000, 0); chk("pp_drained", s_w_sel_valid, 0);

    // randomized traffic; a locked requester keeps its valid high
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      av = N'($urandom);
      if (locked) av[lock_idx] = 1'b1;
      step(av, $urandom_range(0, 3) != 0, N'($urandom), N'($urandom),
           $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
